// File: rtl/slave_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : slave_reg_bank
// Description : Crossbar slave exposing a bank of pDepth registers with
//               byte-enable writes, programmable wait states and an error
//               response for addresses beyond the implemented depth.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_reg_bank #(
    parameter int pData_W      = 32,
    parameter int pAddr_W      = 4,
    parameter int pDepth       = 16,
    parameter int pInit_Delay  = 50,
    parameter int pWait_States = 0
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   slave_req,
    input  logic                   slave_cmd,
    input  logic [pAddr_W-1:0]     slave_addr,
    input  logic [pData_W/8-1:0]   slave_be,
    input  logic [pData_W-1:0]     slave_wdata,
    output logic                   slave_ack,
    output logic                   slave_err,
    output logic [pData_W-1:0]     slave_rdata,
    output logic                   slave_ready
);

    localparam int c_BE_W   = pData_W / 8;
    localparam int c_INIT_W = $clog2(pInit_Delay + 1);
    localparam int c_WAIT_W = 4;

    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(pInit_Delay);
    localparam logic [c_INIT_W-1:0] c_INIT_ONE  = c_INIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(pWait_States);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    // RESP is the cycle before the ack: the access and the ack pulse are
    // registered on the edge that leaves RESP, so ack is visible in TURN.
    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_TURN = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_capture;
    logic                   w_commit;
    logic                   w_in_range;
    logic [pData_W-1:0]     w_rd_word;

    logic [c_INIT_W-1:0]    r_init_cnt;
    logic [c_WAIT_W-1:0]    r_wait_cnt;

    logic                   r_cap_cmd;
    logic [pAddr_W-1:0]     r_cap_addr;
    logic [c_BE_W-1:0]      r_cap_be;
    logic [pData_W-1:0]     r_cap_wdata;

    logic [pData_W-1:0]     r_bank [pDepth];

    logic                   r_ack;
    logic                   r_err;
    logic [pData_W-1:0]     r_rdata;
    logic                   r_ready;

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; requests are only looked at while IDLE
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (slave_req) begin
                    w_capture    = 1'b1;
                    w_state_next = (pWait_States > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_TURN;
            ST_TURN: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Access decode on the captured request; out-of-range reads yield zero
    always_comb begin
        w_commit   = (r_state == ST_RESP);
        w_in_range = (int'(r_cap_addr) < pDepth);
        w_rd_word  = '0;
        for (int w = 0; w < pDepth; w++) begin
            if (int'(r_cap_addr) == w) begin
                w_rd_word = r_bank[w];
            end
        end
    end

    // Power-up delay and wait-state counters, both restart at 1
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_init_cnt <= c_INIT_ONE;
            r_wait_cnt <= c_WAIT_ONE;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= (r_init_cnt == c_INIT_LAST) ? c_INIT_ONE
                                                          : r_init_cnt + c_INIT_ONE;
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= (r_wait_cnt == c_WAIT_LAST) ? c_WAIT_ONE
                                                          : r_wait_cnt + c_WAIT_ONE;
            end else begin
                r_wait_cnt <= c_WAIT_ONE;
            end
        end
    end

    // Capture the request so the master inputs are don't-care afterwards
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cap_cmd   <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_be    <= '0;
            r_cap_wdata <= '0;
        end else if (w_capture) begin
            r_cap_cmd   <= slave_cmd;
            r_cap_addr  <= slave_addr;
            r_cap_be    <= slave_be;
            r_cap_wdata <= slave_wdata;
        end
    end

    // Register bank: byte-lane merge of in-range writes
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int w = 0; w < pDepth; w++) begin
                r_bank[w] <= '0;
            end
        end else if (w_commit && r_cap_cmd) begin
            for (int w = 0; w < pDepth; w++) begin
                if (int'(r_cap_addr) == w) begin
                    for (int b = 0; b < c_BE_W; b++) begin
                        if (r_cap_be[b]) begin
                            r_bank[w][b*8 +: 8] <= r_cap_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Response outputs; rdata only changes when a read completes
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ack   <= w_commit;
            r_err   <= w_commit && !w_in_range;
            r_ready <= (w_state_next == ST_IDLE);
            if (w_commit && !r_cap_cmd) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign slave_ack   = r_ack;
    assign slave_err   = r_err;
    assign slave_rdata = r_rdata;
    assign slave_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_slave_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_reg_bank
// Description : Self-checking bench for slave_reg_bank with a behavioural
//               memory model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_reg_bank;

    localparam int c_DW     = 32;
    localparam int c_AW     = 4;
    localparam int c_DEPTH  = 12;
    localparam int c_INIT   = 50;
    localparam int c_WAIT   = 3;
    // Edges from the request being driven in IDLE up to the ack edge
    localparam int c_LAT    = c_WAIT + 2;
    localparam int c_PERIOD = c_WAIT + 3;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              req   = 1'b0;
    logic              cmd   = 1'b0;
    logic [c_AW-1:0]   addr  = '0;
    logic [3:0]        be    = '0;
    logic [c_DW-1:0]   wdata = '0;
    logic              ack;
    logic              err;
    logic [c_DW-1:0]   rdata;
    logic              ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem [16];
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          ack_cyc;
        logic        ack_after;
        logic        rdy_after;
    } res_t;

    slave_reg_bank #(
        .pData_W      (c_DW),
        .pAddr_W      (c_AW),
        .pDepth       (c_DEPTH),
        .pInit_Delay  (c_INIT),
        .pWait_States (c_WAIT)
    ) dut (
        .iClk        (clk),
        .iRst        (rst),
        .slave_req   (req),
        .slave_cmd   (cmd),
        .slave_addr  (addr),
        .slave_be    (be),
        .slave_wdata (wdata),
        .slave_ack   (ack),
        .slave_err   (err),
        .slave_rdata (rdata),
        .slave_ready (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: a flat array, with the read-hold register tracked separately
    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        last_rd = '0;
    endfunction

    function automatic void model_access(input logic c, input logic [3:0] a, input logic [3:0] b,
                                         input logic [31:0] d,
                                         output logic [31:0] exp_rd, output logic exp_er);
        exp_er = (int'(a) >= c_DEPTH);
        if (c) begin
            if (!exp_er)
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem[a][8*i +: 8] = d[8*i +: 8];
            exp_rd = last_rd;
        end else begin
            exp_rd  = exp_er ? 32'h0 : mem[a];
            last_rd = exp_rd;
        end
    endfunction

    // Drive one transaction from an IDLE cycle, wait for ack, then step into IDLE
    task automatic do_txn(input logic c, input logic [3:0] a, input logic [3:0] b,
                          input logic [31:0] d, output res_t r);
        req = 1'b1; cmd = c; addr = a; be = b; wdata = d;
        r.lat = -1; r.ack_cyc = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                r.lat = n; r.ack_cyc = cyc;
                break;
            end
        end
        r.rd = rdata; r.er = err;
        req = 1'b0; cmd = 1'($urandom); addr = 4'($urandom); be = 4'($urandom); wdata = $urandom;
        @(posedge clk); #1;
        r.ack_after = ack; r.rdy_after = ready;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; req = 1'b1; cmd = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, err, ready, rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b ready=%b rdata=%h expected all zero",
                     ack, err, ready, rdata);
        end
        model_reset();
        rst = 1'b0;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n !== c_INIT) begin
            errors++;
            $display("FAIL init_ready_edges: got %0d expected %0d", n, c_INIT);
        end
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n !== c_LAT) begin
            errors++;
            $display("FAIL init_held_req_ack_edges: got %0d expected %0d", n, c_LAT);
        end
        checks++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL init_read_addr0: got rdata=%h err=%b expected rdata=0 err=0", rdata, err);
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_enable();
        res_t r;
        logic [31:0] e_rd;
        logic e_er;
        model_access(1'b1, 4'd3, 4'hF, 32'hAABBCCDD, e_rd, e_er);
        do_txn(1'b1, 4'd3, 4'hF, 32'hAABBCCDD, r);
        model_access(1'b1, 4'd3, 4'h5, 32'h11223344, e_rd, e_er);
        do_txn(1'b1, 4'd3, 4'h5, 32'h11223344, r);
        checks++;
        if (r.er !== 1'b0) begin
            errors++;
            $display("FAIL be_write_err: got %b expected 0", r.er);
        end
        model_access(1'b0, 4'd3, 4'h0, 32'h0, e_rd, e_er);
        do_txn(1'b0, 4'd3, 4'h0, 32'h0, r);
        checks++;
        if (r.rd !== 32'hAA22CC44 || r.er !== 1'b0) begin
            errors++;
            $display("FAIL be_merge_read: got rdata=%h err=%b expected rdata=aa22cc44 err=0", r.rd, r.er);
        end
        // A write must leave the last read value on rdata
        model_access(1'b1, 4'd4, 4'hF, 32'h5A5A0F0F, e_rd, e_er);
        do_txn(1'b1, 4'd4, 4'hF, 32'h5A5A0F0F, r);
        checks++;
        if (r.rd !== e_rd) begin
            errors++;
            $display("FAIL write_holds_rdata: got %h expected %h", r.rd, e_rd);
        end
        for (int i = 0; i < 5; i++) begin
            logic [3:0] a;
            a = (i == 4) ? 4'd11 : 4'(i + (i >= 3 ? 1 : 0));
            model_access(1'b0, a, 4'h0, 32'h0, e_rd, e_er);
            do_txn(1'b0, a, 4'h0, 32'h0, r);
            checks++;
            if (r.rd !== e_rd || r.er !== e_er) begin
                errors++;
                $display("FAIL other_addr_read[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                         a, r.rd, r.er, e_rd, e_er);
            end
        end
    endtask

    task automatic test_wait_states();
        int first, second;
        logic prev, dbl;
        logic [31:0] e_rd;
        logic e_er;
        first = -1; second = -1; prev = 1'b0; dbl = 1'b0;
        req = 1'b1; cmd = 1'b0; addr = 4'd5; be = 4'h0;
        // Request held through TURN: the second capture must wait for IDLE
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1 && prev === 1'b1) dbl = 1'b1;
            prev = ack;
            if (ack === 1'b1) begin
                if (first < 0) first = i;
                else begin second = i; break; end
            end
        end
        req = 1'b0;
        model_access(1'b0, 4'd5, 4'h0, 32'h0, e_rd, e_er);
        model_access(1'b0, 4'd5, 4'h0, 32'h0, e_rd, e_er);
        checks++;
        if (first !== c_LAT) begin
            errors++;
            $display("FAIL wait_ack_latency: got %0d expected %0d", first, c_LAT);
        end
        checks++;
        if (second - first !== c_PERIOD) begin
            errors++;
            $display("FAIL wait_held_req_period: got %0d expected %0d", second - first, c_PERIOD);
        end
        checks++;
        if (dbl !== 1'b0) begin
            errors++;
            $display("FAIL ack_single_pulse: got %b expected 0", dbl);
        end
        checks++;
        if (rdata !== e_rd || err !== e_er) begin
            errors++;
            $display("FAIL wait_read_addr5: got rdata=%h err=%b expected rdata=%h err=%b", rdata, err, e_rd, e_er);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        res_t r;
        logic [31:0] e_rd;
        logic e_er;
        model_access(1'b1, 4'd13, 4'hF, 32'hDEADBEEF, e_rd, e_er);
        do_txn(1'b1, 4'd13, 4'hF, 32'hDEADBEEF, r);
        checks++;
        if (r.er !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_err: got %b expected 1", r.er);
        end
        model_access(1'b0, 4'd13, 4'h0, 32'h0, e_rd, e_er);
        do_txn(1'b0, 4'd13, 4'h0, 32'h0, r);
        checks++;
        if (r.er !== 1'b1 || r.rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: got rdata=%h err=%b expected rdata=0 err=1", r.rd, r.er);
        end
        model_access(1'b0, 4'd11, 4'h0, 32'h0, e_rd, e_er);
        do_txn(1'b0, 4'd11, 4'h0, 32'h0, r);
        checks++;
        if (r.er !== 1'b0 || r.rd !== e_rd) begin
            errors++;
            $display("FAIL last_word_read: got rdata=%h err=%b expected rdata=%h err=0", r.rd, r.er, e_rd);
        end
        // First out-of-range address and addresses an aliasing decoder would hit
        for (int i = 0; i < 3; i++) begin
            logic [3:0] a;
            a = (i == 0) ? 4'd12 : (i == 1) ? 4'd1 : 4'd15;
            model_access(1'b0, a, 4'h0, 32'h0, e_rd, e_er);
            do_txn(1'b0, a, 4'h0, 32'h0, r);
            checks++;
            if (r.er !== e_er || r.rd !== e_rd) begin
                errors++;
                $display("FAIL range_read[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                         a, r.rd, r.er, e_rd, e_er);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        logic [31:0] e_rd;
        logic e_er;
        logic [31:0] d;
        int prev_ack;
        prev_ack = -1;
        for (int i = 0; i < 8; i++) begin
            logic c;
            c = (i % 2 == 0);
            d = $urandom;
            model_access(c, 4'd0, 4'hF, d, e_rd, e_er);
            do_txn(c, 4'd0, 4'hF, d, r);
            if (!c) begin
                checks++;
                if (r.rd !== e_rd || r.er !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_read[%0d]: got rdata=%h err=%b expected rdata=%h err=0", i, r.rd, r.er, e_rd);
                end
            end
            if (prev_ack >= 0) begin
                checks++;
                if (r.ack_cyc - prev_ack !== c_PERIOD) begin
                    errors++;
                    $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, r.ack_cyc - prev_ack, c_PERIOD);
                end
            end
            prev_ack = r.ack_cyc;
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [31:0] e_rd;
        logic e_er;
        for (int i = 0; i < 40; i++) begin
            logic c;
            logic [3:0] a, b;
            logic [31:0] d;
            c = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom);
            d = $urandom;
            model_access(c, a, b, d, e_rd, e_er);
            do_txn(c, a, b, d, r);
            checks++;
            if (r.rd !== e_rd || r.er !== e_er) begin
                errors++;
                $display("FAIL rand_resp[%0d] cmd=%b addr=%0d be=%h: got rdata=%h err=%b expected rdata=%h err=%b",
                         i, c, a, b, r.rd, r.er, e_rd, e_er);
            end
            checks++;
            if (r.lat !== c_LAT || r.ack_after !== 1'b0 || r.rdy_after !== 1'b1) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d ack_after=%b ready=%b expected lat=%0d ack_after=0 ready=1",
                         i, r.lat, r.ack_after, r.rdy_after, c_LAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        logic seen;
        int n;
        logic [31:0] e_rd;
        logic e_er;
        model_access(1'b1, 4'd1, 4'hF, 32'hCAFEF00D, e_rd, e_er);
        do_txn(1'b1, 4'd1, 4'hF, 32'hCAFEF00D, r);
        req = 1'b1; cmd = 1'b1; addr = 4'd1; be = 4'hF; wdata = 32'h12345678;
        @(posedge clk); #1;
        seen = ack;
        @(posedge clk); #1;
        seen = seen | ack;
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        seen = seen | ack;
        checks++;
        if (ready !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%b ack=%b expected 0 0", ready, ack);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            seen = seen | ack;
            if (ready === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n !== c_INIT) begin
            errors++;
            $display("FAIL reinit_edges: got %0d expected %0d", n, c_INIT);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_no_ack: got %b expected 0", seen);
        end
        for (int i = 0; i < 2; i++) begin
            logic [3:0] a;
            a = (i == 0) ? 4'd1 : 4'd3;
            model_access(1'b0, a, 4'h0, 32'h0, e_rd, e_er);
            do_txn(1'b0, a, 4'h0, 32'h0, r);
            checks++;
            if (r.rd !== e_rd || r.er !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_read[%0d]: got rdata=%h err=%b expected rdata=%h err=0", a, r.rd, r.er, e_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
